conv_mac_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle 3×3 convolution core. Takes one K×K window and K×K weights per handshake beat, one input channel per beat, and accumulates across a channel group delimited by `in_last`. At the end of the group it adds bias, applies optional ReLU, a rounding right-shift and signed saturation, then presents one output pixel through a valid/ready register. Sits between the line-buffer/window generator and the output-feature-map writer.

---
 rtl/conv_pkg.sv | 33 +++
 rtl/mac_tree.sv | 83 ++++++++
 rtl/conv_mac_pipe.sv | 111 +++++++++++
 tb/tb_conv_mac_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, width helpers and saturation for the
// pipelined K x K convolution MAC (mac_tree, conv_mac_pipe).
package conv_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_KERNEL     = 3;

    function automatic int TAPS(input int k);
        return k * k;
    endfunction

    function automatic int SUM_WIDTH(input int dw, input int k);
        return 2 * dw + $clog2(k * k);
    endfunction

    typedef logic signed [2*DEF_DATA_WIDTH-1:0] prod_t;
    typedef logic signed [SUM_WIDTH(DEF_DATA_WIDTH, DEF_KERNEL)-1:0] sum_t;

    // Clamp v into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/mac_tree.sv
// mac_tree: S1 tap multiplies and S2 registered adder tree.
// Ports: clk/rst, clear (flush), en (global advance), in_take (beat
// accepted), in_last/in_window/in_weights/in_bias (beat, tap i at bits
// [i*DATA_WIDTH +: DATA_WIDTH], tap 0 top-left), s2_* (registered S2 beat).
module mac_tree
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KERNEL     = 3,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     clear,
    input  logic                                     en,
    input  logic                                     in_take,
    input  logic                                     in_last,
    input  logic [TAPS(KERNEL)*DATA_WIDTH-1:0]       in_window,
    input  logic [TAPS(KERNEL)*DATA_WIDTH-1:0]       in_weights,
    input  logic [ACC_WIDTH-1:0]                     in_bias,
    output logic                                     s2_valid,
    output logic                                     s2_last,
    output logic signed [SUM_WIDTH(DATA_WIDTH, KERNEL)-1:0] s2_sum,
    output logic signed [ACC_WIDTH-1:0]              s2_bias
);

    localparam int NT = TAPS(KERNEL);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = SUM_WIDTH(DATA_WIDTH, KERNEL);

    logic signed [PW-1:0] prod [NT];
    logic                 v1;
    logic                 last1;
    logic [ACC_WIDTH-1:0] bias1;
    logic signed [SW-1:0] tsum;

    // S1: products registered alongside last and bias.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            bias1 <= '0;
            for (int i = 0; i < NT; i++) prod[i] <= '0;
        end else if (clear) begin
            v1 <= 1'b0;
        end else if (en) begin
            v1 <= in_take;
            if (in_take) begin
                last1 <= in_last;
                bias1 <= in_bias;
                for (int i = 0; i < NT; i++) begin
                    prod[i] <= PW'($signed(in_window[i*DATA_WIDTH +: DATA_WIDTH]))
                             * PW'($signed(in_weights[i*DATA_WIDTH +: DATA_WIDTH]));
                end
            end
        end
    end

    always_comb begin
        tsum = '0;
        for (int i = 0; i < NT; i++) tsum = tsum + SW'(prod[i]);
    end

    // S2: registered tap sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_sum   <= '0;
            s2_bias  <= '0;
        end else if (clear) begin
            s2_valid <= 1'b0;
        end else if (en) begin
            s2_valid <= v1;
            if (v1) begin
                s2_last <= last1;
                s2_sum  <= tsum;
                s2_bias <= $signed(bias1);
            end
        end
    end

endmodule

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined K x K MAC accumulating over a channel group,
// then bias, optional ReLU, rounding shift and saturation.
// Ports: clk/rst, clear, in_* beat handshake (valid/ready/last, window,
// weights, bias), cfg_shift/cfg_relu, out_* result handshake
// (valid/ready, data, raw acc+bias, sat flag).
module conv_mac_pipe
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL      = 3,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_last,
    input  logic [TAPS(KERNEL)*DATA_WIDTH-1:0] in_window,
    input  logic [TAPS(KERNEL)*DATA_WIDTH-1:0] in_weights,
    input  logic [ACC_WIDTH-1:0]               in_bias,
    input  logic [SHIFT_WIDTH-1:0]             cfg_shift,
    input  logic                               cfg_relu,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [ACC_WIDTH-1:0]               out_acc,
    output logic                               out_sat
);

    localparam int SW = SUM_WIDTH(DATA_WIDTH, KERNEL);

    logic                        advance;
    logic                        take;
    logic                        s2_valid;
    logic                        s2_last;
    logic signed [SW-1:0]        s2_sum;
    logic signed [ACC_WIDTH-1:0] s2_bias;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum_ext;
    logic signed [ACC_WIDTH-1:0] total;
    logic signed [63:0]          wide;
    logic signed [63:0]          clamped;
    logic                        sat;

    // Whole pipeline stalls only when a held result is not taken.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !clear && !rst;
    assign take     = in_valid && in_ready;

    mac_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .KERNEL     (KERNEL),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_tree (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .en         (advance),
        .in_take    (take),
        .in_last    (in_last),
        .in_window  (in_window),
        .in_weights (in_weights),
        .in_bias    (in_bias),
        .s2_valid   (s2_valid),
        .s2_last    (s2_last),
        .s2_sum     (s2_sum),
        .s2_bias    (s2_bias)
    );

    // Post-processing runs in 64 bits so the rounding add cannot wrap.
    always_comb begin
        sum_ext = ACC_WIDTH'(s2_sum);
        total   = acc + sum_ext + s2_bias;
        wide    = 64'(total);
        if (cfg_relu && total < 0) wide = '0;
        if (cfg_shift != '0) begin
            wide = (wide + (64'sd1 << (cfg_shift - SHIFT_WIDTH'(1))))
                 >>> cfg_shift;
        end
        clamped = sat_signed(wide, DATA_WIDTH);
        sat     = (clamped != wide);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid && s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    acc      <= '0;
                    out_data <= clamped[DATA_WIDTH-1:0];
                    out_acc  <= total;
                    out_sat  <= sat;
                end else begin
                    acc <= acc + sum_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb_conv_mac_pipe: directed self-checking bench for conv_mac_pipe.
// Drives beats at clock boundaries and samples 1 ns after rising edges.
module tb_conv_mac_pipe;

    localparam int DW  = 8;
    localparam int K   = 3;
    localparam int AW  = 32;
    localparam int SHW = 5;
    localparam int NT  = K * K;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [NT*DW-1:0]  in_window;
    logic [NT*DW-1:0]  in_weights;
    logic [AW-1:0]     in_bias;
    logic [SHW-1:0]    cfg_shift;
    logic              cfg_relu;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [AW-1:0]     out_acc;
    logic              out_sat;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] rd;
    logic [AW-1:0] ra;
    logic          rs;
    logic [NT*DW-1:0] wt5;

    conv_mac_pipe #(
        .DATA_WIDTH  (DW),
        .KERNEL      (K),
        .ACC_WIDTH   (AW),
        .SHIFT_WIDTH (SHW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_window  (in_window),
        .in_weights (in_weights),
        .in_bias    (in_bias),
        .cfg_shift  (cfg_shift),
        .cfg_relu   (cfg_relu),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_acc    (out_acc),
        .out_sat    (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NT*DW-1:0] fill(input logic [DW-1:0] v);
        logic [NT*DW-1:0] f;
        for (int i = 0; i < NT; i++) f[i*DW +: DW] = v;
        return f;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [NT*DW-1:0] win,
                        input logic [NT*DW-1:0] wt,
                        input logic last,
                        input logic [AW-1:0] bias);
        int n;
        in_window  = win;
        in_weights = wt;
        in_last    = last;
        in_bias    = bias;
        in_valid   = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_wait", 64'(n < 50), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get(output logic [DW-1:0] d, output logic [AW-1:0] a,
                       output logic s);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("get_wait", 64'(n < 20), 1);
        d = out_data;
        a = out_acc;
        s = out_sat;
    endtask

    initial begin
        rst        = 1'b1;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_window  = '0;
        in_weights = '0;
        in_bias    = '0;
        cfg_shift  = '0;
        cfg_relu   = 1'b0;
        out_ready  = 1'b1;
        wt5        = '0;
        wt5[DW-1:0] = 8'd5;

        // Reset state
        #12;
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_out_acc", 64'(out_acc), 0);
        chk("rst_out_sat", 64'(out_sat), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 1);

        // One beat, latency 2
        send(fill(8'd1), fill(8'd2), 1'b1, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_t1_valid", 64'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_t2_valid", 64'(out_valid), 1);
        chk("t1_data", $signed(out_data), 18);
        chk("t1_acc", $signed(out_acc), 18);
        chk("t1_sat", 64'(out_sat), 0);

        // Three beats, bias 10, shift 2
        @(posedge clk);
        #1;
        cfg_shift = 5'd2;
        send(fill(8'd1), fill(8'd2), 1'b0, 32'd0);
        send(fill(8'd1), fill(8'd2), 1'b0, 32'd0);
        send(fill(8'd1), fill(8'd2), 1'b1, 32'd10);
        get(rd, ra, rs);
        chk("t2_acc", $signed(ra), 64);
        chk("t2_data", $signed(rd), 16);
        chk("t2_sat", 64'(rs), 0);
        @(posedge clk);
        #1;
        cfg_shift = 5'd0;

        // Positive saturation
        send(fill(8'd127), fill(8'd127), 1'b1, 32'd0);
        get(rd, ra, rs);
        chk("pos_acc", $signed(ra), 145161);
        chk("pos_data", $signed(rd), 127);
        chk("pos_sat", 64'(rs), 1);

        // Negative saturation
        send(fill(8'd127), fill(8'h80), 1'b1, 32'd0);
        get(rd, ra, rs);
        chk("neg_acc", $signed(ra), -146304);
        chk("neg_data", $signed(rd), -128);
        chk("neg_sat", 64'(rs), 1);

        // ReLU
        @(posedge clk);
        #1;
        cfg_relu = 1'b1;
        send(fill(8'd127), fill(8'h80), 1'b1, 32'd0);
        get(rd, ra, rs);
        chk("relu_acc", $signed(ra), -146304);
        chk("relu_data", $signed(rd), 0);
        chk("relu_sat", 64'(rs), 0);
        @(posedge clk);
        #1;
        cfg_relu = 1'b0;

        // Back-pressure: two single-beat groups (9 then 27)
        out_ready = 1'b0;
        send(fill(8'd1), fill(8'd1), 1'b1, 32'd0);
        send(fill(8'd1), fill(8'd3), 1'b1, 32'd0);
        get(rd, ra, rs);
        chk("stall_first", $signed(rd), 9);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 64'(out_valid), 1);
            chk("stall_data", $signed(out_data), 9);
            chk("stall_acc", $signed(out_acc), 9);
            chk("stall_in_ready", 64'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_second_valid", 64'(out_valid), 1);
        chk("stall_second_data", $signed(out_data), 27);
        chk("stall_second_acc", $signed(out_acc), 27);
        @(posedge clk);
        #1;
        chk("stall_drained", 64'(out_valid), 0);

        // clear mid-group, with a coincident last beat
        send(fill(8'd1), fill(8'd2), 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        in_window  = fill(8'd10);
        in_weights = fill(8'd1);
        in_last    = 1'b1;
        in_bias    = 32'd0;
        in_valid   = 1'b1;
        clear      = 1'b1;
        #1;
        chk("clear_in_ready", 64'(in_ready), 0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("clear_out_valid", 64'(out_valid), 0);
        send(fill(8'd1), wt5, 1'b1, 32'd0);
        get(rd, ra, rs);
        chk("clear_next_data", $signed(rd), 5);
        chk("clear_next_acc", $signed(ra), 5);

        // rst mid-group
        @(posedge clk);
        #1;
        send(fill(8'd1), fill(8'd2), 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 0);
        chk("midrst_in_ready", 64'(in_ready), 0);
        chk("midrst_data", 64'(out_data), 0);
        chk("midrst_acc", 64'(out_acc), 0);
        @(negedge clk);
        rst = 1'b0;
        send(fill(8'd1), wt5, 1'b1, 32'd0);
        get(rd, ra, rs);
        chk("midrst_next_data", $signed(rd), 5);
        chk("midrst_next_acc", $signed(ra), 5);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
